// File: rtl/cache_refill.sv
// Line-fill engine: fetches one cache line a word at a time and pulses store_o with the packed line.
// Define CACHE_REFILL_CWF_EN for critical-word-first ordering plus the cw_valid_o/cw_data_o outputs.
module cache_refill #(
  parameter int N_CACHELINE_LENGTH = 4,
  parameter int BITSIZE            = 32
) (
  input  logic                                  clk,
  input  logic                                  rstn_i,
  input  logic                                  miss_i,
  input  logic [BITSIZE-1:0]                    miss_addr_i,
  output logic                                  ready_o,
  output logic                                  mem_req_o,
  output logic [BITSIZE-1:0]                    mem_addr_o,
  input  logic                                  mem_gnt_i,
  input  logic                                  mem_rvalid_i,
  input  logic [BITSIZE-1:0]                    mem_rdata_i,
  output logic                                  store_o,
  output logic [BITSIZE*N_CACHELINE_LENGTH-1:0] line_o,
  output logic [BITSIZE-1:0]                    line_addr_o,
`ifdef CACHE_REFILL_CWF_EN
  output logic                                  cw_valid_o,
  output logic [BITSIZE-1:0]                    cw_data_o,
`endif
  output logic [1:0]                            dbg_state_o,
  output logic [$clog2(N_CACHELINE_LENGTH)-1:0] dbg_crit_off_o
);
  localparam int OFFW = $clog2(N_CACHELINE_LENGTH);
  localparam int TAGW = BITSIZE - OFFW;
  localparam int CNTW = OFFW + 1;
  localparam logic [CNTW-1:0] LAST_CNT = CNTW'(N_CACHELINE_LENGTH - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_WAIT = 2'd2,
    S_DONE = 2'd3
  } state_t;

  // Memory handshake: mem_req_o/mem_addr_o stay stable until mem_gnt_i is sampled high;
  // mem_rvalid_i is consumed only in S_WAIT, so a grant and rvalid in the same cycle never
  // deliver data for the request being granted.
  state_t                                       r_state;
  logic [TAGW-1:0]                              r_tag;
  logic [OFFW-1:0]                              r_off;
  logic [OFFW-1:0]                              r_crit_off;
  logic [CNTW-1:0]                              r_cnt;
  logic [N_CACHELINE_LENGTH-1:0][BITSIZE-1:0]   r_buf;
  logic [N_CACHELINE_LENGTH-1:0][BITSIZE-1:0]   r_line;
  logic [BITSIZE-1:0]                           r_line_addr;
  logic                                         r_ready;
  logic                                         r_req;
  logic [BITSIZE-1:0]                           r_addr;
  logic                                         r_store;

  logic [OFFW-1:0]                              w_start;
  logic [OFFW-1:0]                              w_off_inc;
  logic [N_CACHELINE_LENGTH-1:0][BITSIZE-1:0]   w_buf_next;

`ifdef CACHE_REFILL_CWF_EN
  assign w_start = miss_addr_i[OFFW-1:0];
`else
  assign w_start = '0;
`endif

  // Offset arithmetic stays inside OFFW bits, so wrapping never disturbs the tag.
  assign w_off_inc = r_off + OFFW'(1);

  always_comb begin
    w_buf_next        = r_buf;
    w_buf_next[r_off] = mem_rdata_i;
  end

  always_ff @(posedge clk or negedge rstn_i) begin
    if (!rstn_i) begin
      r_state     <= S_IDLE;
      r_tag       <= '0;
      r_off       <= '0;
      r_crit_off  <= '0;
      r_cnt       <= '0;
      r_buf       <= '0;
      r_line      <= '0;
      r_line_addr <= '0;
      r_ready     <= 1'b1;
      r_req       <= 1'b0;
      r_addr      <= '0;
      r_store     <= 1'b0;
    end else begin
      r_store <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (miss_i) begin
            r_tag      <= miss_addr_i[BITSIZE-1:OFFW];
            r_crit_off <= miss_addr_i[OFFW-1:0];
            r_off      <= w_start;
            r_cnt      <= '0;
            r_req      <= 1'b1;
            r_addr     <= {miss_addr_i[BITSIZE-1:OFFW], w_start};
            r_ready    <= 1'b0;
            r_state    <= S_REQ;
          end
        end
        S_REQ: begin
          if (mem_gnt_i) begin
            r_req   <= 1'b0;
            r_state <= S_WAIT;
          end
        end
        S_WAIT: begin
          if (mem_rvalid_i) begin
            r_buf <= w_buf_next;
            r_off <= w_off_inc;
            r_cnt <= r_cnt + CNTW'(1);
            if (r_cnt == LAST_CNT) begin
              r_line      <= w_buf_next;
              r_line_addr <= {r_tag, {OFFW{1'b0}}};
              r_store     <= 1'b1;
              r_state     <= S_DONE;
            end else begin
              r_req   <= 1'b1;
              r_addr  <= {r_tag, w_off_inc};
              r_state <= S_REQ;
            end
          end
        end
        S_DONE: begin
          r_ready <= 1'b1;
          r_state <= S_IDLE;
        end
        default: begin
          r_state <= S_IDLE;
          r_ready <= 1'b1;
          r_req   <= 1'b0;
        end
      endcase
    end
  end

`ifdef CACHE_REFILL_CWF_EN
  logic               r_cw_valid;
  logic [BITSIZE-1:0] r_cw_data;

  // The first word returned is always the requested (critical) word.
  always_ff @(posedge clk or negedge rstn_i) begin
    if (!rstn_i) begin
      r_cw_valid <= 1'b0;
      r_cw_data  <= '0;
    end else begin
      r_cw_valid <= 1'b0;
      if (r_state == S_WAIT && mem_rvalid_i && r_cnt == '0) begin
        r_cw_valid <= 1'b1;
        r_cw_data  <= mem_rdata_i;
      end
    end
  end

  assign cw_valid_o = r_cw_valid;
  assign cw_data_o  = r_cw_data;
`endif

  assign ready_o        = r_ready;
  assign mem_req_o      = r_req;
  assign mem_addr_o     = r_addr;
  assign store_o        = r_store;
  assign line_o         = r_line;
  assign line_addr_o    = r_line_addr;
  assign dbg_state_o    = r_state;
  assign dbg_crit_off_o = r_crit_off;

endmodule

// File: tb/tb_cache_refill.sv
// Self-checking bench for cache_refill: vector table, multi-cycle corner sequences and a
// randomized phase scored against an address/memory-level reference model.
module tb_cache_refill;
  localparam int N  = 4;
  localparam int W  = 32;
  localparam int LW = N * W;
  localparam int OW = $clog2(N);

  logic          clk = 1'b0;
  logic          rstn_i = 1'b0;
  logic          miss_i = 1'b0;
  logic [W-1:0]  miss_addr_i = '0;
  logic          ready_o;
  logic          mem_req_o;
  logic [W-1:0]  mem_addr_o;
  logic          mem_gnt_i = 1'b0;
  logic          mem_rvalid_i = 1'b0;
  logic [W-1:0]  mem_rdata_i = '0;
  logic          store_o;
  logic [LW-1:0] line_o;
  logic [W-1:0]  line_addr_o;
  logic [1:0]    dbg_state_o;
  logic [OW-1:0] dbg_crit_off_o;
`ifdef CACHE_REFILL_CWF_EN
  logic          cw_valid_o;
  logic [W-1:0]  cw_data_o;
`endif

  cache_refill #(.N_CACHELINE_LENGTH(N), .BITSIZE(W)) dut (
    .clk(clk), .rstn_i(rstn_i), .miss_i(miss_i), .miss_addr_i(miss_addr_i),
    .ready_o(ready_o), .mem_req_o(mem_req_o), .mem_addr_o(mem_addr_o),
    .mem_gnt_i(mem_gnt_i), .mem_rvalid_i(mem_rvalid_i), .mem_rdata_i(mem_rdata_i),
    .store_o(store_o), .line_o(line_o), .line_addr_o(line_addr_o),
`ifdef CACHE_REFILL_CWF_EN
    .cw_valid_o(cw_valid_o), .cw_data_o(cw_data_o),
`endif
    .dbg_state_o(dbg_state_o), .dbg_crit_off_o(dbg_crit_off_o)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- scoreboard state ----------------
  int n_chk = 0;
  int n_pass = 0;
  logic [W-1:0] exp_q[$];
  logic [W-1:0] got_q[$];

  task automatic check(input string name, input logic [LW-1:0] got, input logic [LW-1:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, got, exp);
  endtask

  // ---------------- memory model + responder ----------------
  bit           directed_data = 1'b1;
  logic [W-1:0] data_salt = '0;
  bit           rand_lat = 1'b0;
  int           junk_mode = 0;   // 0 none, 1 random, 2 every non-WAIT cycle
  int           stall_idx = -1;
  int           stall_len = 0;
  int           req_idx = 0;
  int           req_age = 0;
  int           cur_lat = 0;
  bit           rv_pend = 1'b0;
  int           rv_cnt = 0;
  logic [W-1:0] rv_addr = '0;
  int           rv_seen = 0;
  bit           prev_req_nogrant = 1'b0;
  logic [W-1:0] prev_addr = '0;
  int           hold_err = 0;
  int           store_cnt = 0;
  int           cw_cnt = 0;
  logic [W-1:0] cw_last = '0;

  function automatic logic [W-1:0] mem_fn(input logic [W-1:0] a);
    if (directed_data) return 32'hA0 + (a % W'(N));
    return data_salt ^ (a * 32'h9E37_79B1);
  endfunction

  always @(negedge clk) begin
    if (!rstn_i) begin
      mem_gnt_i = 1'b0;
      mem_rvalid_i = 1'b0;
      rv_pend = 1'b0;
      req_age = 0;
      prev_req_nogrant = 1'b0;
    end else begin
      if (prev_req_nogrant && (!mem_req_o || mem_addr_o != prev_addr)) hold_err++;
      if (store_o) store_cnt++;
`ifdef CACHE_REFILL_CWF_EN
      if (cw_valid_o) begin
        cw_cnt++;
        cw_last = cw_data_o;
      end
`endif
      mem_rvalid_i = 1'b0;
      mem_rdata_i = $urandom;
      if (rv_pend) begin
        if (rv_cnt == 0) begin
          mem_rvalid_i = 1'b1;
          mem_rdata_i = mem_fn(rv_addr);
          rv_pend = 1'b0;
          rv_seen++;
        end else rv_cnt--;
      end else if ((ready_o || mem_req_o || store_o) &&
                   (junk_mode == 2 || (junk_mode == 1 && $urandom_range(0, 1) == 1))) begin
        mem_rvalid_i = 1'b1;
      end
      mem_gnt_i = 1'b0;
      if (mem_req_o) begin
        if (req_age == 0)
          cur_lat = (req_idx == stall_idx) ? stall_len : (rand_lat ? $urandom_range(0, 3) : 0);
        if (req_age >= cur_lat) begin
          mem_gnt_i = 1'b1;
          rv_pend = 1'b1;
          rv_cnt = rand_lat ? $urandom_range(0, 3) : 0;
          rv_addr = mem_addr_o;
          got_q.push_back(mem_addr_o);
          req_idx++;
          req_age = 0;
        end else req_age++;
      end
      prev_req_nogrant = mem_req_o && !mem_gnt_i;
      prev_addr = mem_addr_o;
    end
  end

  // ---------------- reference model ----------------
  function automatic logic [W-1:0] line_base(input logic [W-1:0] a);
    return a & ~W'(N - 1);
  endfunction

  function automatic int start_off(input logic [W-1:0] a);
`ifdef CACHE_REFILL_CWF_EN
    return int'(a % W'(N));
`else
    return 0;
`endif
  endfunction

  function automatic logic [LW-1:0] model_line(input logic [W-1:0] a);
    logic [LW-1:0] l;
    for (int k = 0; k < N; k++) l[k*W +: W] = mem_fn(line_base(a) + W'(k));
    return l;
  endfunction

  // ---------------- driver tasks ----------------
  task automatic wait_ready();
    int n;
    n = 0;
    while (!ready_o && n < 100) begin
      @(negedge clk);
      n++;
    end
    check("ready before miss", LW'(ready_o), LW'(1));
  endtask

  task automatic run_miss(input logic [W-1:0] addr, input logic [W-1:0] exp_laddr,
                          input logic [LW-1:0] exp_line, input int exp_lat, input bit pulse);
    int cyc;
    int st0;
    int cw0;
    bit ok;
    wait_ready();
    exp_q.delete();
    got_q.delete();
    for (int k = 0; k < N; k++)
      exp_q.push_back(line_base(addr) + W'((start_off(addr) + k) % N));
    req_idx = 0;
    #1;
    st0 = store_cnt;
    cw0 = cw_cnt;
    miss_i = 1'b1;
    miss_addr_i = addr;
    @(negedge clk);
    miss_addr_i = $urandom;
    cyc = 1;
    while (!store_o && cyc < 300) begin
      if (pulse && cyc == 4) begin
        miss_i = 1'b1;
        miss_addr_i = addr ^ 32'h40;
      end else miss_i = 1'b0;
      @(negedge clk);
      cyc++;
    end
    miss_i = 1'b0;
    check("store_o seen", LW'(store_o), LW'(1));
    if (exp_lat >= 0) check("miss to store latency", LW'(cyc), LW'(exp_lat));
    check("line_addr_o", LW'(line_addr_o), LW'(exp_laddr));
    check("line_o", line_o, exp_line);
    ok = (got_q.size() == exp_q.size());
    for (int i = 0; i < exp_q.size() && ok; i++) if (got_q[i] != exp_q[i]) ok = 1'b0;
    check("read address order", LW'(ok), LW'(1));
    @(negedge clk);
    check("store_o single pulse", LW'(store_o), LW'(0));
    check("ready_o after done", LW'(ready_o), LW'(1));
    check("line_o held after done", line_o, exp_line);
    #1;
`ifdef CACHE_REFILL_CWF_EN
    check("cw_valid_o pulse count", LW'(cw_cnt - cw0), LW'(1));
    check("cw_data_o", LW'(cw_last), LW'(mem_fn(addr)));
`endif
    if (pulse) begin
      repeat (3) @(negedge clk);
      #1;
      check("one store per refill", LW'(store_cnt - st0), LW'(1));
    end
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    logic [W-1:0]  miss_addr;
    logic [W-1:0]  exp_line_addr;
    logic [LW-1:0] exp_line;
    int            exp_lat;
  } vec_t;

  vec_t vecs[4];

  initial begin
    logic [LW-1:0] a_line;
    logic [W-1:0]  a;
    int            cyc;
    int            st0;
    int            rv0;

    a_line = {32'hA3, 32'hA2, 32'hA1, 32'hA0};
    vecs[0] = '{32'h0000_0103, 32'h0000_0100, a_line, 9};
    vecs[1] = '{32'h0000_0102, 32'h0000_0100, a_line, 9};
    vecs[2] = '{32'h0000_0000, 32'h0000_0000, a_line, 9};
    vecs[3] = '{32'hFFFF_FFFF, 32'hFFFF_FFFC, a_line, 9};

    // reset values
    repeat (3) @(negedge clk);
    check("reset ready_o", LW'(ready_o), LW'(1));
    check("reset mem_req_o", LW'(mem_req_o), LW'(0));
    check("reset store_o", LW'(store_o), LW'(0));
    check("reset mem_addr_o", LW'(mem_addr_o), LW'(0));
    check("reset line_o", line_o, LW'(0));
    check("reset line_addr_o", LW'(line_addr_o), LW'(0));
    rstn_i = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 4; i++)
      run_miss(vecs[i].miss_addr, vecs[i].exp_line_addr, vecs[i].exp_line, vecs[i].exp_lat, 1'b0);

    // grant stalled on word 1 with stray rvalid while requesting
    stall_idx = 1;
    stall_len = 5;
    junk_mode = 2;
    run_miss(32'h0000_0101, 32'h0000_0100, a_line, 14, 1'b0);
    check("req/addr held during stall", LW'(hold_err), LW'(0));
    stall_idx = -1;
    junk_mode = 0;

    // miss pulsed while busy
    run_miss(32'h0000_0123, 32'h0000_0120, a_line, 9, 1'b1);

    // reset in the middle of a refill
    wait_ready();
    #1;
    st0 = store_cnt;
    rv0 = rv_seen;
    miss_i = 1'b1;
    miss_addr_i = 32'h0000_0301;
    @(negedge clk);
    miss_i = 1'b0;
    cyc = 0;
    while (rv_seen - rv0 < 2 && cyc < 100) begin
      @(negedge clk);
      #1;
      cyc++;
    end
    @(negedge clk);
    rstn_i = 1'b0;
    #1;
    check("mid-refill reset ready_o", LW'(ready_o), LW'(1));
    check("mid-refill reset mem_req_o", LW'(mem_req_o), LW'(0));
    check("mid-refill reset mem_addr_o", LW'(mem_addr_o), LW'(0));
    check("mid-refill reset line_o", line_o, LW'(0));
    check("mid-refill reset line_addr_o", LW'(line_addr_o), LW'(0));
    @(negedge clk);
    rstn_i = 1'b1;
    repeat (12) @(negedge clk);
    #1;
    check("no store after abort", LW'(store_cnt - st0), LW'(0));
    directed_data = 1'b0;
    data_salt = 32'h5A5A_1234;
    run_miss(32'h0000_0200, 32'h0000_0200, model_line(32'h0000_0200), 9, 1'b0);

    // back-to-back misses with miss_i held high
    wait_ready();
    got_q.delete();
    req_idx = 0;
    miss_i = 1'b1;
    miss_addr_i = 32'h0000_0142;
    @(negedge clk);
    cyc = 1;
    while (!store_o && cyc < 100) begin
      @(negedge clk);
      cyc++;
    end
    check("b2b first latency", LW'(cyc), LW'(9));
    check("b2b first line_addr_o", LW'(line_addr_o), LW'(32'h0000_0140));
    check("b2b first line_o", line_o, model_line(32'h0000_0140));
    miss_addr_i = 32'h0000_0187;
    @(negedge clk);
    check("b2b idle cycle ready_o", LW'(ready_o), LW'(1));
    @(negedge clk);
    miss_i = 1'b0;
    cyc = 1;
    while (!store_o && cyc < 100) begin
      @(negedge clk);
      cyc++;
    end
    check("b2b second latency", LW'(cyc), LW'(9));
    check("b2b second line_addr_o", LW'(line_addr_o), LW'(32'h0000_0184));
    check("b2b second line_o", line_o, model_line(32'h0000_0184));

    // randomized refills against the reference model
    rand_lat = 1'b1;
    junk_mode = 1;
    for (int t = 0; t < 24; t++) begin
      data_salt = $urandom;
      a = $urandom;
      run_miss(a, line_base(a), model_line(a), -1, $urandom_range(0, 1) == 1);
    end
    check("req/addr held overall", LW'(hold_err), LW'(0));

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
